// File: rtl/pdec_pkg.sv
// pdec_pkg: shared constants and helpers for the priority decoder tile.
//
// Contents:
//   CODE_W, VEC_W  - code and decoded vector widths
//   CODE_NONE      - code meaning "no bit set" (decodes to all zeros)
//   is_legal()     - true for 8'h00..8'h0F and CODE_NONE
//   decode()       - code -> 16-bit vector
//
// Build option:
//   PDEC_THERMO_EN - when defined, index i decodes to a thermometer mask
//                    (bits i..0 set) instead of a one-hot bit, so the
//                    vector still re-encodes to i through a priority encoder.

package pdec_pkg;

    localparam int CODE_W = 8;
    localparam int VEC_W  = 16;

    localparam logic [CODE_W-1:0] CODE_NONE = 8'hF0;

    function automatic logic is_legal(input logic [CODE_W-1:0] code);
        return (code[7:4] == 4'h0) || (code == CODE_NONE);
    endfunction

    // CODE_NONE and illegal codes both return zero; callers must use
    // is_legal() to decide whether the result may be committed.
    function automatic logic [VEC_W-1:0] decode(input logic [CODE_W-1:0] code);
        logic [VEC_W-1:0] v;
        v = '0;
        if (code[7:4] == 4'h0) begin
`ifdef PDEC_THERMO_EN
            // For index 15 the shift drops out of the 16-bit range, leaving
            // zero; minus one then wraps to all ones, which is the right mask.
            v = (16'h0002 << code[3:0]) - 16'h0001;
`else
            v = 16'h0001 << code[3:0];
`endif
        end
        return v;
    endfunction

endpackage

// File: rtl/pdec_glitch_filter.sv
// pdec_glitch_filter: synchroniser plus stability filter for the code input.
//
// Ports:
//   clk_i     in   rising-edge clock
//   rst_ni    in   synchronous active-low reset
//   ena_i     in   enable; low freezes every register here
//   code_i    in   raw asynchronous code
//   commit_o  out  high in a cycle where code_o has been seen unchanged for
//                  STABLE_CYCLES+1 synced samples (stays high while stable)
//   code_o    out  current candidate code
//
// The commit strobe is combinational from registers only; the top registers
// the decoded value on the same edge, giving SYNC_STAGES+1+STABLE_CYCLES
// edges from an input change to an output change.

module pdec_glitch_filter
    import pdec_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ena_i,
    input  logic [CODE_W-1:0] code_i,
    output logic              commit_o,
    output logic [CODE_W-1:0] code_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [CODE_W-1:0] sync_q [SYNC_STAGES];
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] sample;
    logic              commit;

    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (ena_i) begin
            if (sample != cand_q) begin
                cand_d = sample;
                cnt_d  = '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                // Counter saturates here; repeated commits of the same
                // candidate leave the output unchanged.
                commit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= CODE_NONE;
            end
            cand_q <= CODE_NONE;
            cnt_q  <= '0;
        end else if (ena_i) begin
            sync_q[0] <= code_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign commit_o = commit;
    assign code_o   = cand_q;

endmodule

// File: rtl/tt_um_priority_decoder.sv
// tt_um_priority_decoder: Tiny Tapeout tile that turns an 8-bit priority
// encoder result code back into a 16-bit vector.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   ena      in   tile enable; low freezes all state
//   ui_in    in   code: 8'h00..8'h0F = index, 8'hF0 = no bit set
//   uio_in   in   unused
//   uo_out   out  decoded vector bits[15:8]
//   uio_out  out  decoded vector bits[7:0]
//   uio_oe   out  constant 8'hFF
//
// Build option: PDEC_THERMO_EN selects thermometer decode (see pdec_pkg).
// Illegal codes are filtered like any other but never committed, so the
// output keeps its last legal value. Outputs come straight from registers.

module tt_um_priority_decoder
    import pdec_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic              commit;
    logic [CODE_W-1:0] cand_code;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic              unused_uio;

    assign unused_uio = &{1'b0, uio_in};

    pdec_glitch_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .ena_i    (ena),
        .code_i   (ui_in),
        .commit_o (commit),
        .code_o   (cand_code)
    );

    always_comb begin
        vec_d = vec_q;
        if (commit && is_legal(cand_code)) begin
            vec_d = decode(cand_code);
        end
    end

    // commit is already gated by ena, so no separate enable is needed here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign uo_out  = vec_q[15:8];
    assign uio_out = vec_q[7:0];
    assign uio_oe  = 8'hFF;

endmodule
